// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client and seq_divider.
// Latency: none (wires only).
// Backpressure: none; the client must watch busy, and start is ignored while busy.
interface seq_divider_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    // Client side: issues operands, observes results.
    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned 16/8 divider, one quotient bit per clock, MSB first.
// Latency: done is high 17 edges after the accepting edge (1 edge for divide by zero).
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
module seq_divider (
    input  logic          clk,
    input  logic          reset_a,
    seq_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // The dividend register shifts its MSB out into the partial remainder
    // each step and takes the new quotient bit in at the bottom, so after
    // 16 steps it holds the finished quotient.
    logic [15:0] dvd_sh;
    logic [7:0]  dvs;
    logic [3:0]  cnt;
    logic [8:0]  prem;

    logic [15:0] quo;
    logic [7:0]  rem;
    logic        dbz;

    logic        accept;
    logic        last_step;

    // One guard bit above the 9-bit partial remainder so the borrow of the
    // trial subtraction shows up as the MSB.
    logic [9:0]  shifted;
    logic [9:0]  trial;
    logic        qbit;
    logic [8:0]  prem_nxt;

    assign accept    = (state == IDLE) && bus.start;
    assign last_step = (state == CALC) && (cnt == 4'd15);

    // Trial subtraction for the current step.
    always_comb begin
        shifted  = {prem, dvd_sh[15]};
        trial    = shifted - {2'b00, dvs};
        qbit     = ~trial[9];
        prem_nxt = qbit ? trial[8:0] : shifted[8:0];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a zero divisor skips straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.divisor == 8'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == 4'd15) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch and per-step datapath.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            dvd_sh <= 16'h0000;
            dvs    <= 8'h00;
            cnt    <= 4'd0;
            prem   <= 9'h000;
        end else if (accept) begin
            dvd_sh <= bus.dividend;
            dvs    <= bus.divisor;
            cnt    <= 4'd0;
            prem   <= 9'h000;
        end else if (state == CALC) begin
            dvd_sh <= {dvd_sh[14:0], qbit};
            prem   <= prem_nxt;
            cnt    <= cnt + 4'd1;
        end
    end

    // Result registers: written only when an operation completes, held otherwise.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            quo <= 16'h0000;
            rem <= 8'h00;
            dbz <= 1'b0;
        end else if (accept && (bus.divisor == 8'd0)) begin
            quo <= 16'hFFFF;
            rem <= 8'h00;
            dbz <= 1'b1;
        end else if (last_step) begin
            quo <= {dvd_sh[14:0], qbit};
            rem <= prem_nxt[7:0];
            dbz <= 1'b0;
        end
    end

    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse, including latency,
// busy duration and hold of the result registers between completions.
module tb_seq_divider;

    logic clk = 1'b0;
    logic reset_a;

    always #5 clk = ~clk;

    seq_divider_if bus();

    seq_divider dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    logic [15:0] hold_q = 16'h0;
    logic [7:0]  hold_r = 8'h0;
    logic        hold_z = 1'b0;
    int          busy_n = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_a) begin
                busy_n = 0;
                hold_q = 16'h0;
                hold_r = 8'h0;
                hold_z = 1'b0;
            end else begin
                if (bus.busy) busy_n++;
                if (bus.busy && !bus.done && busy_n == 8)
                    check("hold_mid_calc", {bus.quotient, bus.remainder, bus.div_by_zero},
                          {hold_q, hold_r, hold_z});
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("quotient", bus.quotient, e.q);
                        check("remainder", bus.remainder, e.r);
                        check("div_by_zero", bus.div_by_zero, e.dbz);
                        check("latency", cyc + 1 - e.acc, e.lat);
                        check("busy_cycles", busy_n, e.lat);
                        hold_q = e.q;
                        hold_r = e.r;
                        hold_z = e.dbz;
                    end
                    busy_n = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.busy && k < 40);
        check("idle_wait", bus.busy, 1'b0);
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic edz);
        exp_t e;
        wait_idle();
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        e.q = eq; e.r = er; e.dbz = edz; e.acc = cyc + 1; e.lat = edz ? 1 : 17;
        sb.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("drain", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [15:0] ra;
        logic [7:0]  rb;

        reset_a      = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 16'h0;
        bus.divisor  = 8'h0;

        // Reset values before any clock edge.
        #3;
        check("rst_quotient", bus.quotient, 16'h0000);
        check("rst_remainder", bus.remainder, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset_a = 1'b1;

        // Basic operation and boundary operands.
        issue(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0);
        drain();
        issue(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
        issue(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
        issue(16'h0064, 8'hC8, 16'h0000, 8'h64, 1'b0);
        drain();

        // Divide by zero followed immediately by a normal operation.
        issue(16'h0005, 8'h00, 16'hFFFF, 8'h00, 1'b1);
        issue(16'h0009, 8'h03, 16'h0003, 8'h00, 1'b0);
        drain();
        issue(16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0);
        issue(16'h1234, 8'h56, 16'h0036, 8'h10, 1'b0);
        drain();

        // Idle with start low and moving operands: nothing changes.
        @(negedge clk);
        bus.dividend = 16'h0001;
        bus.divisor  = 8'h02;
        repeat (3) @(negedge clk);
        check("idle_hold", {bus.quotient, bus.remainder, bus.div_by_zero, bus.busy, bus.done},
              {16'h0036, 8'h10, 1'b0, 1'b0, 1'b0});

        // start re-pulsed with new operands in CALC cycle 5 is ignored.
        issue(16'hABCD, 8'h0D, 16'h0D37, 8'h02, 1'b0);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'h0001;
        bus.divisor  = 8'h01;
        @(negedge clk);
        bus.start    = 1'b0;
        drain();

        // start held high: second acceptance lands in the first IDLE cycle after DONE.
        wait_idle();
        bus.dividend = 16'h0064;
        bus.divisor  = 8'h07;
        bus.start    = 1'b1;
        e.q = 16'h000E; e.r = 8'h02; e.dbz = 1'b0; e.lat = 17;
        e.acc = cyc + 1;
        sb.push_back(e);
        e.acc = cyc + 19;
        sb.push_back(e);
        repeat (19) @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Reset in CALC cycle 8 aborts with no done pulse.
        issue(16'h7777, 8'h09, 16'h0D46, 8'h01, 1'b0);
        repeat (7) @(negedge clk);
        #2 reset_a = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_calc", {bus.quotient, bus.remainder, bus.div_by_zero, bus.busy, bus.done},
              {16'h0000, 8'h00, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        #2 reset_a = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", {bus.busy, bus.done}, 2'b00);
        issue(16'h00FF, 8'h10, 16'h000F, 8'h0F, 1'b0);
        drain();

        // Randomized run against a behavioural reference.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = (i % 50 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            if (rb == 8'h00)
                issue(ra, rb, 16'hFFFF, 8'h00, 1'b1);
            else
                issue(ra, rb, ra / {8'h00, rb}, 8'(ra % {8'h00, rb}), 1'b0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
